rom_readback: RTL and testbench

ROM_READBACK -- requirements
Module: rom_readback

---
 rtl/rom_readback.sv | 146 ++++++++++++++
 tb/tb_rom_readback.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_readback.sv
`default_nettype none
// ============================================================================
// rom_readback : one-word cached byte readback of SDRAM-held ROM for upload.
// Option macro ROM_READBACK_TIMEOUT_EN bounds the SDRAM wait and flags rd_err.
// Revision     : 1.0
// ============================================================================
module rom_readback #(
    parameter logic [15:0] ROM_INDEX   = 16'h1,
    parameter int          TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        RSTn,
    input  logic        ioctl_upload,
    input  logic [15:0] ioctl_index,
    input  logic        ioctl_rd,
    input  logic [24:0] ioctl_addr,
    output logic [7:0]  ioctl_din,
    output logic        ioctl_wait,
    output logic [24:0] sdr_addr,
    output logic        sdr_req,
    input  logic        sdr_rdy,
    input  logic [15:0] sdr_dout,
    output logic        rd_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    generate
        if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_timeout_range
            $error("rom_readback: TIMEOUT_CYC must be 1..255");
        end
    endgenerate

    state_t      r_state;
    logic        r_upload_d;
    logic        r_valid;
    logic [23:0] r_tag;
    logic [15:0] r_data;
    logic        r_sel;
    logic [7:0]  r_resp_byte;

    logic        w_active;
    logic        w_upload_rise;
    logic        w_hit;

`ifdef ROM_READBACK_TIMEOUT_EN
    localparam logic [7:0] C_TIMEOUT_LAST = 8'(TIMEOUT_CYC - 1);
    logic [7:0]  r_tmo_cnt;
`else
    assign rd_err = 1'b0;
`endif

    function automatic logic [7:0] sel_byte(input logic [15:0] word, input logic hi);
        return hi ? word[15:8] : word[7:0];
    endfunction

    assign w_active      = ioctl_rd & ioctl_upload & (ioctl_index == ROM_INDEX);
    assign w_upload_rise = ioctl_upload & ~r_upload_d;
    // A read landing on the upload-start edge must not hit stale cache contents.
    assign w_hit         = r_valid & ~w_upload_rise & (r_tag == ioctl_addr[24:1]);

    always_ff @(posedge clk) begin
        if (!RSTn) begin
            r_state     <= S_IDLE;
            r_upload_d  <= 1'b0;
            r_valid     <= 1'b0;
            r_tag       <= 24'd0;
            r_data      <= 16'd0;
            r_sel       <= 1'b0;
            r_resp_byte <= 8'h00;
            ioctl_din   <= 8'h00;
            ioctl_wait  <= 1'b0;
            sdr_addr    <= 25'd0;
            sdr_req     <= 1'b0;
`ifdef ROM_READBACK_TIMEOUT_EN
            r_tmo_cnt   <= 8'd0;
            rd_err      <= 1'b0;
`endif
        end else begin
            r_upload_d <= ioctl_upload;
            if (w_upload_rise) begin
                r_valid <= 1'b0;
`ifdef ROM_READBACK_TIMEOUT_EN
                rd_err  <= 1'b0;
`endif
            end

            case (r_state)
                S_IDLE: begin
                    if (w_active) begin
                        if (w_hit) begin
                            ioctl_din <= sel_byte(r_data, ioctl_addr[0]);
                        end else begin
                            ioctl_wait <= 1'b1;
                            sdr_req    <= 1'b1;
                            sdr_addr   <= {ioctl_addr[24:1], 1'b0};
                            r_sel      <= ioctl_addr[0];
                            r_state    <= S_REQ;
`ifdef ROM_READBACK_TIMEOUT_EN
                            r_tmo_cnt  <= 8'd0;
`endif
                        end
                    end
                end

                // Upload ending mid-request does not abort: the fill completes.
                S_REQ: begin
                    if (sdr_rdy) begin
                        r_data      <= sdr_dout;
                        r_tag       <= sdr_addr[24:1];
                        r_valid     <= 1'b1;
                        r_resp_byte <= sel_byte(sdr_dout, r_sel);
                        sdr_req     <= 1'b0;
                        r_state     <= S_RESP;
                    end
`ifdef ROM_READBACK_TIMEOUT_EN
                    else if (r_tmo_cnt == C_TIMEOUT_LAST) begin
                        r_resp_byte <= 8'hFF;
                        rd_err      <= 1'b1;
                        sdr_req     <= 1'b0;
                        r_state     <= S_RESP;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 8'd1;
                    end
`endif
                end

                S_RESP: begin
                    ioctl_din  <= r_resp_byte;
                    ioctl_wait <= 1'b0;
                    r_state    <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rom_readback.sv
`default_nettype none
// ============================================================================
// tb_rom_readback : scoreboard bench for rom_readback with an SDRAM model.
// Timeout scenario runs only when ROM_READBACK_TIMEOUT_EN is defined.
// Revision        : 1.0
// ============================================================================
module tb_rom_readback;

    logic        clk = 1'b0;
    logic        RSTn = 1'b0;
    logic        ioctl_upload = 1'b0;
    logic [15:0] ioctl_index = 16'h1;
    logic        ioctl_rd = 1'b0;
    logic [24:0] ioctl_addr = 25'd0;
    logic [7:0]  ioctl_din;
    logic        ioctl_wait;
    logic [24:0] sdr_addr;
    logic        sdr_req;
    logic        sdr_rdy = 1'b0;
    logic [15:0] sdr_dout = 16'h0;
    logic        rd_err;

    rom_readback #(
        .ROM_INDEX  (16'h1),
        .TIMEOUT_CYC(16)
    ) dut (
        .clk         (clk),
        .RSTn        (RSTn),
        .ioctl_upload(ioctl_upload),
        .ioctl_index (ioctl_index),
        .ioctl_rd    (ioctl_rd),
        .ioctl_addr  (ioctl_addr),
        .ioctl_din   (ioctl_din),
        .ioctl_wait  (ioctl_wait),
        .sdr_addr    (sdr_addr),
        .sdr_req     (sdr_req),
        .sdr_rdy     (sdr_rdy),
        .sdr_dout    (sdr_dout),
        .rd_err      (rd_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  din;
        int          waitc;
        int          nreq;
        logic [24:0] addr;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] mem_word(input logic [24:0] a);
        case (a)
            25'h0000100: return 16'hA55A;
            25'h1FFFFFE: return 16'h1234;
            25'h0000000: return 16'hBEEF;
            25'h0000200: return 16'hC3D4;
            25'h0000400: return 16'h7788;
            default:     return 16'h0000;
        endcase
    endfunction

    // SDRAM model: rdy in the (lat+1)-th cycle that sdr_req is seen high
    int   lat = 5;
    int   mcnt = 0;
    logic inject_rdy = 1'b0;
    always @(negedge clk) begin
        if (sdr_req) mcnt++;
        else mcnt = 0;
        if (inject_rdy) begin
            sdr_rdy    = 1'b1;
            sdr_dout   = 16'hDEAD;
            inject_rdy = 1'b0;
        end else if (sdr_req && mcnt == lat + 1) begin
            sdr_rdy  = 1'b1;
            sdr_dout = mem_word(sdr_addr);
        end else begin
            sdr_rdy = 1'b0;
        end
    end

    // Monitor: accepted reads are seen at posedge, responses checked at negedge
    logic acc = 1'b0;
    logic rst_seen = 1'b0;
    always @(posedge clk) begin
        acc      <= RSTn & ioctl_rd & ~ioctl_wait;
        rst_seen <= ~RSTn;
    end

    logic        pending = 1'b0;
    logic        req_prev = 1'b0;
    int          waitc = 0;
    int          rises = 0;
    logic [24:0] cap_addr = 25'd0;
    always @(negedge clk) begin
        exp_t e;
        if (acc) begin
            pending = 1'b1;
            waitc   = 0;
            rises   = 0;
        end
        if (rst_seen) pending = 1'b0;
        if (sdr_req && !req_prev) begin
            rises++;
            cap_addr = sdr_addr;
        end
        req_prev = sdr_req;
        if (pending) begin
            if (ioctl_wait) begin
                waitc++;
                if (waitc > 5000) begin
                    chk("wait_bound", 32'(waitc), 32'd5000);
                    pending = 1'b0;
                end
            end else begin
                pending = 1'b0;
                if (sb.size() == 0) begin
                    chk("unexpected_response", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("din", 32'(ioctl_din), 32'(e.din));
                    chk("wait_cycles", 32'(waitc), 32'(e.waitc));
                    chk("sdr_req_count", 32'(rises), 32'(e.nreq));
                    if (e.nreq == 1) chk("sdr_addr", 32'(cap_addr), 32'(e.addr));
                    chk("rd_err", 32'(rd_err), 32'(e.err));
                end
            end
        end
    end

    task automatic pulse_rd(input logic [24:0] a, input logic [15:0] idx);
        @(negedge clk);
        ioctl_rd    = 1'b1;
        ioctl_addr  = a;
        ioctl_index = idx;
        @(negedge clk);
        ioctl_rd    = 1'b0;
        ioctl_index = 16'h1;
    endtask

    task automatic issue(input logic [24:0] a, input logic [15:0] idx, input logic [7:0] din,
                         input int wc, input int nreq, input logic [24:0] sa, input logic err);
        exp_t e;
        e.din = din; e.waitc = wc; e.nreq = nreq; e.addr = sa; e.err = err;
        sb.push_back(e);
        pulse_rd(a, idx);
    endtask

    task automatic drain();
        for (int i = 0; i < 3000 && (sb.size() != 0 || pending); i++) @(negedge clk);
        if (sb.size() != 0 || pending) begin
            chk("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
            pending = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_din", 32'(ioctl_din), 32'h00);
        chk("rst_wait", 32'(ioctl_wait), 32'd0);
        chk("rst_req", 32'(sdr_req), 32'd0);
        chk("rst_addr", 32'(sdr_addr), 32'd0);
        chk("rst_err", 32'(rd_err), 32'd0);
        RSTn = 1'b1;
        @(negedge clk);
        ioctl_upload = 1'b1;
        @(negedge clk);

        lat = 5; issue(25'h100, 16'h1, 8'h5A, 7, 1, 25'h100, 1'b0); drain();
        issue(25'h101, 16'h1, 8'hA5, 0, 0, 25'h0, 1'b0); drain();
        issue(25'h100, 16'h0, 8'hA5, 0, 0, 25'h0, 1'b0); drain();
        ioctl_upload = 1'b0;
        issue(25'h100, 16'h1, 8'hA5, 0, 0, 25'h0, 1'b0); drain();
        @(negedge clk); ioctl_upload = 1'b1;
        lat = 1; issue(25'h101, 16'h1, 8'hA5, 3, 1, 25'h100, 1'b0); drain();
        issue(25'h1FFFFFF, 16'h1, 8'h12, 3, 1, 25'h1FFFFFE, 1'b0); drain();
        lat = 0; issue(25'h0, 16'h1, 8'hEF, 2, 1, 25'h0, 1'b0); drain();
        issue(25'h1, 16'h1, 8'hBE, 0, 0, 25'h0, 1'b0); drain();

        // upload drops while the request is outstanding
        lat = 3; issue(25'h200, 16'h1, 8'hD4, 5, 1, 25'h200, 1'b0);
        @(negedge clk); ioctl_upload = 1'b0;
        drain();
        @(negedge clk); ioctl_upload = 1'b1;

        // long SDRAM latency with a stray read during the stall
        lat = 1000; issue(25'h100, 16'h1, 8'h5A, 1002, 1, 25'h100, 1'b0);
        repeat (10) @(negedge clk);
        pulse_rd(25'h101, 16'h1);
        drain();

        // reset while in REQ, followed by a late sdr_rdy
        lat = 100000;
        pulse_rd(25'h400, 16'h1);
        repeat (2) @(negedge clk);
        chk("req_before_rst", 32'(sdr_req), 32'd1);
        RSTn = 1'b0;
        @(negedge clk);
        RSTn = 1'b1;
        chk("rst_req_drop", 32'(sdr_req), 32'd0);
        chk("rst_din_clr", 32'(ioctl_din), 32'h00);
        inject_rdy = 1'b1;
        repeat (4) @(negedge clk);
        chk("late_rdy_req", 32'(sdr_req), 32'd0);
        chk("late_rdy_wait", 32'(ioctl_wait), 32'd0);
        chk("late_rdy_din", 32'(ioctl_din), 32'h00);
        lat = 2; issue(25'h400, 16'h1, 8'h88, 4, 1, 25'h400, 1'b0); drain();
        issue(25'h401, 16'h1, 8'h77, 0, 0, 25'h0, 1'b0); drain();

`ifdef ROM_READBACK_TIMEOUT_EN
        lat = 100000; issue(25'h300, 16'h1, 8'hFF, 17, 1, 25'h300, 1'b1); drain();
        chk("err_sticky", 32'(rd_err), 32'd1);
        ioctl_upload = 1'b0;
        @(negedge clk); ioctl_upload = 1'b1;
        repeat (2) @(negedge clk);
        chk("err_cleared", 32'(rd_err), 32'd0);
`endif

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
